// File: rtl/vme_cap_pkg.sv
// Shared types and helpers for the VME sample-RAM capture sequencer.
//   cap_state_e  - capture FSM states
//   AddrWDefault - default RAM address width
//   CntWDefault  - default event / missed-trigger counter width
//   sat_inc()    - saturating increment for counters up to SatW bits wide
package vme_cap_pkg;

    localparam int unsigned AddrWDefault = 12;
    localparam int unsigned CntWDefault  = 16;
    localparam int unsigned SatW         = 32;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StArmed,
        StPost,
        StDone
    } cap_state_e;

    // Increment val, holding at the all-ones value of a width-bit counter.
    function automatic logic [SatW-1:0] sat_inc(input logic [SatW-1:0] val,
                                                input int unsigned      width);
        logic [SatW-1:0] max_val;
        max_val = '1;
        max_val = max_val >> (SatW - width);
        return (val >= max_val) ? max_val : val + 1'b1;
    endfunction

endpackage

// File: rtl/vme_cap_len_ctr.sv
// Loadable down-counter with zero flag, timing the PRE and POST write runs.
//   clk      - system clock
//   rst      - synchronous active-low reset
//   load_i   - load load_val_i (has priority over dec_i)
//   load_val_i - value to load
//   dec_i    - decrement by one
//   zero_o   - count is zero
module vme_cap_len_ctr #(
    parameter int unsigned W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/vme_ram_capture_ctrl.sv
// Trigger-capture write sequencer for the VME-readable circular sample RAM.
// Writes one sample per clock, keeps pre_len samples before and post_len samples after
// the trigger sample, then holds the window until the VME side acknowledges readout.
//   clk, rst             - clock, synchronous active-low reset
//   arm                  - start a capture (IDLE only)
//   trig_in              - trigger level
//   mode_cont            - re-arm automatically after rd_done
//   pre_len, post_len    - window lengths, latched at arm
//   rd_done              - window consumed by VME readout
//   wr_ena, wr_addr      - RAM write strobe / address for the current cycle
//   busy, done           - capture in progress / window valid
//   trig_addr, win_start - trigger sample address / window start address
//   cfg_err              - window did not fit at last arm; post length was clamped
//   evt_cnt, miss_cnt    - accepted / missed triggers, saturating
module vme_ram_capture_ctrl
    import vme_cap_pkg::*;
#(
    parameter int unsigned ADDR_W = AddrWDefault,
    parameter int unsigned CNT_W  = CntWDefault
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              trig_in,
    input  logic              mode_cont,
    input  logic [ADDR_W-1:0] pre_len,
    input  logic [ADDR_W-1:0] post_len,
    input  logic              rd_done,
    output logic              wr_ena,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] win_start,
    output logic              cfg_err,
    output logic [CNT_W-1:0]  evt_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    cap_state_e        state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] pre_len_q, pre_len_d;
    logic [ADDR_W-1:0] post_len_q, post_len_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] win_start_q, win_start_d;
    logic              cfg_err_q, cfg_err_d;
    logic [CNT_W-1:0]  evt_cnt_q, evt_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic              active_q, done_q;
    logic              trig_q;

    logic              trig_rise;
    logic              start;
    logic [ADDR_W:0]   len_sum;
    logic              len_ovf;
    logic              ctr_load, ctr_dec, ctr_zero;
    logic [ADDR_W-1:0] ctr_load_val;

    assign trig_rise = trig_in & ~trig_q;

    // Window fits only if pre + post + 1 <= DEPTH, i.e. pre + post <= DEPTH-1.
    assign len_sum = {1'b0, pre_len} + {1'b0, post_len};
    assign len_ovf = len_sum > {1'b0, {ADDR_W{1'b1}}};

    vme_cap_len_ctr #(
        .W(ADDR_W)
    ) u_len_ctr (
        .clk       (clk),
        .rst       (rst),
        .load_i    (ctr_load),
        .load_val_i(ctr_load_val),
        .dec_i     (ctr_dec),
        .zero_o    (ctr_zero)
    );

    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        pre_len_d    = pre_len_q;
        post_len_d   = post_len_q;
        trig_addr_d  = trig_addr_q;
        win_start_d  = win_start_q;
        cfg_err_d    = cfg_err_q;
        evt_cnt_d    = evt_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        ctr_load     = 1'b0;
        ctr_load_val = '0;
        ctr_dec      = 1'b0;
        start        = 1'b0;

        unique case (state_q)
            StIdle: begin
                start = arm;
            end
            StPre: begin
                wr_addr_d = wr_addr_q + 1'b1;
                if (trig_rise) begin
                    miss_cnt_d = CNT_W'(sat_inc(SatW'(miss_cnt_q), CNT_W));
                end
                // Counter was loaded with pre_len-1, so zero marks the last PRE write.
                if (ctr_zero) begin
                    state_d = StArmed;
                end else begin
                    ctr_dec = 1'b1;
                end
            end
            StArmed: begin
                if (trig_in) begin
                    trig_addr_d = wr_addr_q;
                    win_start_d = wr_addr_q - pre_len_q;
                    evt_cnt_d   = CNT_W'(sat_inc(SatW'(evt_cnt_q), CNT_W));
                    if (post_len_q != '0) begin
                        state_d      = StPost;
                        wr_addr_d    = wr_addr_q + 1'b1;
                        ctr_load     = 1'b1;
                        ctr_load_val = post_len_q - 1'b1;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    wr_addr_d = wr_addr_q + 1'b1;
                end
            end
            StPost: begin
                if (trig_rise) begin
                    miss_cnt_d = CNT_W'(sat_inc(SatW'(miss_cnt_q), CNT_W));
                end
                // The address freezes on the last POST write for the DONE hold.
                if (ctr_zero) begin
                    state_d = StDone;
                end else begin
                    ctr_dec   = 1'b1;
                    wr_addr_d = wr_addr_q + 1'b1;
                end
            end
            StDone: begin
                if (trig_rise) begin
                    miss_cnt_d = CNT_W'(sat_inc(SatW'(miss_cnt_q), CNT_W));
                end
                if (rd_done) begin
                    if (mode_cont) begin
                        start = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Arm from IDLE and continuous re-arm from DONE share one start path.
        if (start) begin
            pre_len_d = pre_len;
            wr_addr_d = '0;
            if (len_ovf) begin
                cfg_err_d  = 1'b1;
                post_len_d = ~pre_len;  // DEPTH-1-pre_len
            end else begin
                cfg_err_d  = 1'b0;
                post_len_d = post_len;
            end
            if (pre_len != '0) begin
                state_d      = StPre;
                ctr_load     = 1'b1;
                ctr_load_val = pre_len - 1'b1;
            end else begin
                state_d = StArmed;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            wr_addr_q   <= '0;
            pre_len_q   <= '0;
            post_len_q  <= '0;
            trig_addr_q <= '0;
            win_start_q <= '0;
            cfg_err_q   <= 1'b0;
            evt_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
            trig_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            pre_len_q   <= pre_len_d;
            post_len_q  <= post_len_d;
            trig_addr_q <= trig_addr_d;
            win_start_q <= win_start_d;
            cfg_err_q   <= cfg_err_d;
            evt_cnt_q   <= evt_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            active_q    <= (state_d == StPre) || (state_d == StArmed) || (state_d == StPost);
            done_q      <= (state_d == StDone);
            trig_q      <= trig_in;
        end
    end

    assign wr_ena    = active_q;
    assign busy      = active_q;
    assign done      = done_q;
    assign wr_addr   = wr_addr_q;
    assign trig_addr = trig_addr_q;
    assign win_start = win_start_q;
    assign cfg_err   = cfg_err_q;
    assign evt_cnt   = evt_cnt_q;
    assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_vme_ram_capture_ctrl.sv
// Bench for vme_ram_capture_ctrl: directed scenarios followed by a random input stream,
// every cycle compared against a write-count based reference model.
module tb_vme_ram_capture_ctrl;

    localparam int unsigned AW     = 4;
    localparam int unsigned CW     = 4;
    localparam int          Depth  = 16;
    localparam int          CntMax = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          arm;
    logic          trig_in;
    logic          mode_cont;
    logic [AW-1:0] pre_len;
    logic [AW-1:0] post_len;
    logic          rd_done;
    logic          wr_ena;
    logic [AW-1:0] wr_addr;
    logic          busy;
    logic          done;
    logic [AW-1:0] trig_addr;
    logic [AW-1:0] win_start;
    logic          cfg_err;
    logic [CW-1:0] evt_cnt;
    logic [CW-1:0] miss_cnt;

    vme_ram_capture_ctrl #(
        .ADDR_W(AW),
        .CNT_W (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .arm      (arm),
        .trig_in  (trig_in),
        .mode_cont(mode_cont),
        .pre_len  (pre_len),
        .post_len (post_len),
        .rd_done  (rd_done),
        .wr_ena   (wr_ena),
        .wr_addr  (wr_addr),
        .busy     (busy),
        .done     (done),
        .trig_addr(trig_addr),
        .win_start(win_start),
        .cfg_err  (cfg_err),
        .evt_cnt  (evt_cnt),
        .miss_cnt (miss_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: a capture is a run of numbered writes; write k goes to k mod DEPTH.
    bit m_capt, m_done, m_cfg, m_trig_prev;
    int m_writes, m_pre, m_post, m_tidx, m_taddr, m_win, m_evt, m_miss;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_capt = 0; m_done = 0; m_cfg = 0; m_trig_prev = 0;
        m_writes = 0; m_pre = 0; m_post = 0; m_tidx = -1;
        m_taddr = 0; m_win = 0; m_evt = 0; m_miss = 0;
    endtask

    task automatic model_start();
        m_pre = int'(pre_len);
        if (int'(pre_len) + int'(post_len) + 1 > Depth) begin
            m_cfg  = 1;
            m_post = Depth - 1 - m_pre;
        end else begin
            m_cfg  = 0;
            m_post = int'(post_len);
        end
        m_writes = 0;
        m_tidx   = -1;
        m_capt   = 1;
    endtask

    function automatic int sat(input int v);
        return (v < CntMax) ? v + 1 : CntMax;
    endfunction

    task automatic model_step();
        bit rise;
        if (!rst) begin
            model_reset();
            return;
        end
        rise        = trig_in && !m_trig_prev;
        m_trig_prev = trig_in;
        if (m_capt) begin
            if (m_tidx < 0 && m_writes >= m_pre && trig_in) begin
                m_tidx  = m_writes;
                m_taddr = m_writes % Depth;
                m_win   = ((m_taddr - m_pre) % Depth + Depth) % Depth;
                m_evt   = sat(m_evt);
            end else if (rise) begin
                m_miss = sat(m_miss);
            end
            if (m_tidx >= 0 && m_writes - m_tidx == m_post) begin
                m_capt = 0;
                m_done = 1;
            end else begin
                m_writes++;
            end
        end else if (m_done) begin
            if (rise) m_miss = sat(m_miss);
            if (rd_done) begin
                m_done = 0;
                if (mode_cont) model_start();
            end
        end else if (arm) begin
            model_start();
        end
    endtask

    task automatic check_outputs();
        check_eq("wr_ena",    32'(wr_ena),    32'(m_capt));
        check_eq("wr_addr",   32'(wr_addr),   32'(m_writes % Depth));
        check_eq("busy",      32'(busy),      32'(m_capt));
        check_eq("done",      32'(done),      32'(m_done));
        check_eq("trig_addr", 32'(trig_addr), 32'(m_taddr));
        check_eq("win_start", 32'(win_start), 32'(m_win));
        check_eq("cfg_err",   32'(cfg_err),   32'(m_cfg));
        check_eq("evt_cnt",   32'(evt_cnt),   32'(m_evt));
        check_eq("miss_cnt",  32'(miss_cnt),  32'(m_miss));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 0;
        tick();
        rst = 1;
    endtask

    task automatic arm_with(input int pre, input int post);
        pre_len  = AW'(pre);
        post_len = AW'(post);
        arm      = 1;
        tick();
        arm      = 0;
    endtask

    // Counts write cycles until done rises, bounded by a cycle budget.
    task automatic count_until_done(output int n);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (done) break;
            if (wr_ena) n++;
            tick();
        end
    endtask

    int n_wr;

    initial begin
        model_reset();
        rst = 0; arm = 0; trig_in = 0; mode_cont = 0; rd_done = 0;
        pre_len = '0; post_len = '0;
        tick();
        tick();
        rst = 1;

        // Reset in the middle of POST clears everything; later triggers do nothing.
        arm_with(2, 6);
        repeat (2) tick();
        trig_in = 1; tick(); trig_in = 0;
        repeat (2) tick();
        check_eq("t1_busy_in_post", 32'(busy), 32'd1);
        rst = 0; tick(); rst = 1;
        check_eq("t1_rst_wr_ena", 32'(wr_ena), 32'd0);
        check_eq("t1_rst_evt", 32'(evt_cnt), 32'd0);
        repeat (3) begin
            trig_in = 1; tick();
            check_eq("t1_no_write", 32'(wr_ena), 32'd0);
            trig_in = 0; tick();
        end

        // pre=3, post=4, trigger on the sixth write.
        do_reset();
        arm_with(3, 4);
        check_eq("t2_first_addr", 32'(wr_addr), 32'd0);
        repeat (5) tick();
        trig_in = 1; tick(); trig_in = 0;
        check_eq("t2_trig_addr", 32'(trig_addr), 32'd5);
        check_eq("t2_win_start", 32'(win_start), 32'd2);
        check_eq("t2_post_addr0", 32'(wr_addr), 32'd6);
        count_until_done(n_wr);
        check_eq("t2_post_writes", 32'(n_wr), 32'd4);
        check_eq("t2_done", 32'(done), 32'd1);
        check_eq("t2_evt", 32'(evt_cnt), 32'd1);
        rd_done = 1; tick(); rd_done = 0;

        // ARMED wraps the address before the trigger arrives.
        do_reset();
        arm_with(2, 2);
        repeat (22) tick();
        check_eq("t3_wrapped_addr", 32'(wr_addr), 32'd6);
        trig_in = 1; tick(); trig_in = 0;
        check_eq("t3_trig_addr", 32'(trig_addr), 32'd6);
        check_eq("t3_win_start", 32'(win_start), 32'd4);
        count_until_done(n_wr);
        check_eq("t3_post_writes", 32'(n_wr), 32'd2);
        rd_done = 1; tick(); rd_done = 0;

        // Zero-length window: a single write then done.
        do_reset();
        arm_with(0, 0);
        check_eq("t4_wr_ena", 32'(wr_ena), 32'd1);
        check_eq("t4_addr", 32'(wr_addr), 32'd0);
        trig_in = 1; tick(); trig_in = 0;
        check_eq("t4_done", 32'(done), 32'd1);
        check_eq("t4_wr_ena_off", 32'(wr_ena), 32'd0);
        check_eq("t4_trig_addr", 32'(trig_addr), 32'd0);
        rd_done = 1; tick(); rd_done = 0;

        // Continuous mode: misses in POST and DONE, then automatic re-arm.
        do_reset();
        mode_cont = 1;
        arm_with(2, 3);
        repeat (2) tick();
        trig_in = 1; tick();
        trig_in = 0; tick();
        trig_in = 1; tick();
        trig_in = 0; tick();
        check_eq("t5_done", 32'(done), 32'd1);
        trig_in = 1; tick();
        trig_in = 0; tick();
        check_eq("t5_miss", 32'(miss_cnt), 32'd2);
        rd_done = 1; tick(); rd_done = 0;
        check_eq("t5_rearm_done", 32'(done), 32'd0);
        check_eq("t5_rearm_busy", 32'(busy), 32'd1);
        check_eq("t5_rearm_addr", 32'(wr_addr), 32'd0);
        mode_cont = 0;

        // Oversized window: post length clamped to DEPTH-1-pre.
        do_reset();
        arm_with(10, 10);
        check_eq("t6_cfg_err", 32'(cfg_err), 32'd1);
        repeat (10) tick();
        trig_in = 1; tick(); trig_in = 0;
        count_until_done(n_wr);
        check_eq("t6_post_writes", 32'(n_wr), 32'd5);
        rd_done = 1; tick(); rd_done = 0;
        arm_with(1, 1);
        check_eq("t6_cfg_cleared", 32'(cfg_err), 32'd0);

        // Random stream; the model checks every cycle.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst     = ($urandom_range(0, 299) != 0);
            arm     = ($urandom_range(0, 5) == 0);
            rd_done = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) trig_in = ~trig_in;
            if ($urandom_range(0, 99) == 0) mode_cont = ~mode_cont;
            pre_len  = AW'($urandom_range(0, ($urandom_range(0, 2) == 0) ? 15 : 4));
            post_len = AW'($urandom_range(0, ($urandom_range(0, 2) == 0) ? 15 : 4));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
